// File: rtl/pre_if_fetch.sv
// rtl/pre_if_fetch.sv - fetch front end: PC generation, SRAM-like instruction port, one-word output buffer
module pre_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic [32:0] BR_BUS,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] era_pc,
  input  logic        IF_allow_in,
  output logic        PF_valid,
  output logic [31:0] PF_pc,
  output logic [31:0] PF_inst,
  output logic        PF_excep
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        stale, stale_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic        buf_excep, buf_excep_nxt;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redir;
  logic [31:0] redir_target;
  logic        misaligned;

  assign br_taken     = BR_BUS[0];
  assign br_target    = BR_BUS[32:1];
  assign redir        = ertn_flush | wb_ex | br_taken;
  assign redir_target = ertn_flush ? era_pc : (wb_ex ? ex_entry : br_target);
  assign misaligned   = (req_addr[1:0] != 2'b00);

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  // A misaligned address never reaches the SRAM; it is reported as ADEF instead.
  assign inst_sram_req   = (state == S_REQ) && !misaligned;
  assign inst_sram_addr  = req_addr;

  // A redirect in the hold cycle kills the buffered word before it is handed over.
  assign PF_valid = (state == S_HOLD) && !redir;
  assign PF_pc    = buf_pc;
  assign PF_inst  = buf_inst;
  assign PF_excep = buf_excep;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers: PC, request address, stale flag and output buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      stale     <= 1'b0;
      buf_pc    <= 32'h0;
      buf_inst  <= 32'h0;
      buf_excep <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      stale     <= stale_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_inst  <= buf_inst_nxt;
      buf_excep <= buf_excep_nxt;
    end
  end

  // Next-state and datapath update; any redirect always retargets pc.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = redir ? redir_target : pc;
    req_addr_nxt  = req_addr;
    stale_nxt     = stale;
    buf_pc_nxt    = buf_pc;
    buf_inst_nxt  = buf_inst;
    buf_excep_nxt = buf_excep;
    case (state)
      S_IDLE: begin
        state_nxt    = S_REQ;
        req_addr_nxt = redir ? redir_target : pc;
      end
      S_REQ: begin
        if (misaligned) begin
          // Nothing is in flight, so a redirect can simply replace the address.
          if (redir) begin
            req_addr_nxt = redir_target;
          end else begin
            state_nxt     = S_HOLD;
            buf_pc_nxt    = req_addr;
            buf_inst_nxt  = 32'h0;
            buf_excep_nxt = 1'b1;
          end
        end else begin
          // The address must stay stable until accepted; remember the redirect instead.
          if (redir) stale_nxt = 1'b1;
          if (inst_sram_addr_ok) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (stale || redir) begin
            state_nxt    = S_REQ;
            req_addr_nxt = redir ? redir_target : pc;
            stale_nxt    = 1'b0;
          end else begin
            state_nxt     = S_HOLD;
            buf_pc_nxt    = req_addr;
            buf_inst_nxt  = inst_sram_rdata;
            buf_excep_nxt = 1'b0;
          end
        end else if (redir) begin
          stale_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_nxt    = S_REQ;
          req_addr_nxt = redir_target;
        end else if (IF_allow_in) begin
          state_nxt    = S_REQ;
          pc_nxt       = pc + 32'd4;
          req_addr_nxt = pc + 32'd4;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pre_if_fetch.sv
// tb/tb_pre_if_fetch.sv - self-checking bench for pre_if_fetch with SRAM responder and transaction model
module tb_pre_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [32:0] BR_BUS;
  logic        wb_ex, ertn_flush, IF_allow_in;
  logic [31:0] ex_entry, era_pc;
  logic        PF_valid, PF_excep;
  logic [31:0] PF_pc, PF_inst;

  pre_if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .BR_BUS(BR_BUS),
    .wb_ex(wb_ex), .ex_entry(ex_entry), .ertn_flush(ertn_flush), .era_pc(era_pc),
    .IF_allow_in(IF_allow_in), .PF_valid(PF_valid), .PF_pc(PF_pc),
    .PF_inst(PF_inst), .PF_excep(PF_excep)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  // SRAM responder: addr_ok after addr_lat waiting cycles, data_ok data_lat cycles after acceptance.
  int addr_lat = 1;
  int data_lat = 1;
  int rcnt = 0;
  int dcnt = 0;
  bit pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  initial begin
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (inst_sram_data_ok) pend = 1'b0;
      else if (pend) dcnt++;
      if (inst_sram_req && inst_sram_addr_ok) begin
        pend = 1'b1; pend_addr = inst_sram_addr; dcnt = 0; rcnt = 0;
      end else if (inst_sram_req) rcnt++;
      else rcnt = 0;
      @(posedge clk); #1;
      inst_sram_addr_ok = inst_sram_req && !pend && (rcnt >= addr_lat);
      inst_sram_data_ok = pend && (dcnt >= data_lat);
      inst_sram_rdata   = inst_sram_data_ok ? mem_word(pend_addr) : 32'hdeadbeef;
    end
  end

  // Transaction-level model of the fetch front end.
  typedef struct packed {
    logic        started;
    logic        inflight;
    logic        dead;
    logic        have;
    logic        wexc;
    logic [31:0] pc;
    logic [31:0] issue;
    logic [31:0] wpc;
    logic [31:0] winst;
  } mstate_t;

  mstate_t m;
  logic        m_redir;
  logic [31:0] m_target;
  assign m_redir  = ertn_flush | wb_ex | BR_BUS[0];
  assign m_target = ertn_flush ? era_pc : (wb_ex ? ex_entry : BR_BUS[32:1]);

  function automatic mstate_t model_reset();
    mstate_t s;
    s = '0;
    s.pc = RESET_PC;
    s.issue = RESET_PC;
    return s;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic r, input logic [31:0] t,
                                         input logic allow, input logic aok, input logic dok,
                                         input logic [31:0] rdata);
    mstate_t n;
    n = s;
    if (!s.started) begin
      n.started = 1'b1;
      n.issue = r ? t : s.pc;
    end else if (s.have) begin
      if (r) begin
        n.have = 1'b0; n.issue = t;
      end else if (allow) begin
        n.have = 1'b0; n.pc = s.pc + 32'd4; n.issue = s.pc + 32'd4;
      end
    end else if (s.inflight) begin
      if (dok) begin
        n.inflight = 1'b0;
        if (s.dead || r) begin
          n.dead = 1'b0; n.issue = r ? t : s.pc;
        end else begin
          n.have = 1'b1; n.wpc = s.issue; n.winst = rdata; n.wexc = 1'b0;
        end
      end else if (r) n.dead = 1'b1;
    end else if (s.issue[1:0] != 2'b00) begin
      if (r) n.issue = t;
      else begin
        n.have = 1'b1; n.wpc = s.issue; n.winst = 32'h0; n.wexc = 1'b1;
      end
    end else begin
      if (r) n.dead = 1'b1;
      if (aok) n.inflight = 1'b1;
    end
    if (r) n.pc = t;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= model_step(m, m_redir, m_target, IF_allow_in, inst_sram_addr_ok,
                         inst_sram_data_ok, inst_sram_rdata);
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      logic exp_req, exp_valid;
      @(negedge clk);
      exp_req   = m.started && !m.inflight && !m.have && (m.issue[1:0] == 2'b00);
      exp_valid = m.have && !m_redir;
      check1("model_req", inst_sram_req, exp_req);
      if (exp_req) check32("model_addr", inst_sram_addr, m.issue);
      check1("model_valid", PF_valid, exp_valid);
      if (exp_valid) begin
        check32("model_pf_pc", PF_pc, m.wpc);
        check32("model_pf_inst", PF_inst, m.winst);
        check1("model_pf_excep", PF_excep, m.wexc);
      end
      check1("consts", (inst_sram_wr == 1'b0) && (inst_sram_size == 2'b10) &&
                       (inst_sram_wstrb == 4'b0) && (inst_sram_wdata == 32'h0), 1'b1);
    end
  end

  task automatic at_drive();
    @(posedge clk); #2;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(inst_sram_req && inst_sram_addr == a) && n < 60);
    check32(name, inst_sram_req ? inst_sram_addr : 32'hffffffff, a);
  endtask

  task automatic wait_accept(input logic [31:0] a, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(inst_sram_req && inst_sram_addr_ok) && n < 60);
    check32(name, (inst_sram_req && inst_sram_addr_ok) ? inst_sram_addr : 32'hffffffff, a);
  endtask

  task automatic wait_valid_pc(input logic [31:0] a, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!PF_valid && n < 60);
    check32(name, PF_valid ? PF_pc : 32'hffffffff, a);
  endtask

  initial begin
    int v;
    int n;
    reset = 1'b1; BR_BUS = '0; wb_ex = 1'b0; ex_entry = '0;
    ertn_flush = 1'b0; era_pc = '0; IF_allow_in = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_req", inst_sram_req, 1'b0);
    check1("rst_valid", PF_valid, 1'b0);
    check32("rst_pf_pc", PF_pc, 32'h0);
    check32("rst_pf_inst", PF_inst, 32'h0);
    at_drive(); reset = 1'b0;

    // 1: two sequential words with one-cycle-late addr_ok and data_ok
    wait_req_addr(32'h1c000000, "t1_req0");
    wait_valid_pc(32'h1c000000, "t1_pc0");
    check32("t1_inst0", PF_inst, mem_word(32'h1c000000));
    wait_req_addr(32'h1c000004, "t1_req1");
    wait_valid_pc(32'h1c000004, "t1_pc1");
    at_drive(); IF_allow_in = 1'b0;

    // 2: downstream stall for 5 cycles, then one handshake
    wait_valid_pc(32'h1c000008, "t2_hold_pc");
    repeat (5) begin
      @(negedge clk);
      check1("t2_hold_valid", PF_valid, 1'b1);
      check32("t2_hold_pc_stable", PF_pc, 32'h1c000008);
      check1("t2_hold_no_req", inst_sram_req, 1'b0);
    end
    at_drive(); IF_allow_in = 1'b1;
    wait_req_addr(32'h1c00000c, "t2_next_req");

    // 3: branch while waiting for data
    data_lat = 3;
    wait_accept(32'h1c00000c, "t3_accept");
    at_drive(); BR_BUS = {32'h1c000100, 1'b1};
    at_drive(); BR_BUS = '0;
    v = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (PF_valid) v++;
    end while (!(inst_sram_req && inst_sram_addr == 32'h1c000100) && n < 60);
    check32("t3_redir_req", inst_sram_req ? inst_sram_addr : 32'hffffffff, 32'h1c000100);
    check32("t3_no_valid", v, 0);
    data_lat = 1;
    wait_valid_pc(32'h1c000100, "t3_pc");

    // 4: ertn and exception together while the request waits for addr_ok
    addr_lat = 4;
    wait_req_addr(32'h1c000104, "t4_req");
    at_drive(); ertn_flush = 1'b1; era_pc = 32'h1c000200; wb_ex = 1'b1; ex_entry = 32'h1c000300;
    at_drive(); ertn_flush = 1'b0; wb_ex = 1'b0;
    wait_accept(32'h1c000104, "t4_held_addr");
    wait_req_addr(32'h1c000200, "t4_redir_req");

    // 5: branch to a misaligned target from HOLD
    addr_lat = 1; data_lat = 0;
    at_drive(); IF_allow_in = 1'b0;
    wait_valid_pc(32'h1c000200, "t5_hold");
    at_drive(); BR_BUS = {32'h1c000102, 1'b1};
    @(negedge clk);
    check1("t5_valid_masked", PF_valid, 1'b0);
    at_drive(); BR_BUS = '0;
    wait_valid_pc(32'h1c000102, "t5_excep_pc");
    check1("t5_excep", PF_excep, 1'b1);
    check32("t5_inst", PF_inst, 32'h0);
    check1("t5_no_req", inst_sram_req, 1'b0);
    at_drive(); BR_BUS = {32'h1c000400, 1'b1};
    at_drive(); BR_BUS = '0; IF_allow_in = 1'b1;

    // 6: reset during WAIT; late data_ok must be ignored
    data_lat = 6;
    wait_accept(32'h1c000400, "t6_accept");
    at_drive(); reset = 1'b1;
    @(negedge clk);
    check1("t6_rst_req", inst_sram_req, 1'b0);
    check1("t6_rst_valid", PF_valid, 1'b0);
    at_drive();
    at_drive(); reset = 1'b0;
    wait_req_addr(32'h1c000000, "t6_first_req");
    wait_valid_pc(32'h1c000000, "t6_pc");
    check32("t6_inst", PF_inst, mem_word(32'h1c000000));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
